usb_tx_shifter: RTL
===================

# usb_tx_shifter

Transmit-side byte serializer for the USB full-speed PHY path, sitting directly upstream of the NRZI line encoder. It accepts packet bytes over a valid/ready handshake and prepends the SYNC pattern. It shifts bits out LSB-first at a fixed bit rate, inserts a stuffed zero after six consecutive ones, and then requests the EOP. Its serial_out, enable_pts and send_EOP outputs drive the encoder's inputs of the same name.

## Interface
- CLKS_PER_BIT, 4: clk cycles per USB bit period; must be ≥ 2.
- clk  in  1  system clock.
- n_rst  in  1  reset, asynchronous, active-low.
- tx_data  in  8  packet byte.
- tx_valid  in  1  tx_data/tx_last valid.
- tx_last  in  1  byte is the final byte of the packet.
- tx_ready  out  1  one-byte holding buffer empty; a byte is accepted on tx_valid && tx_ready.
- serial_out  out  1  current bit; 0 causes a line transition in the encoder.
- enable_pts  out  1  one-cycle strobe in the first cycle of every bit period, including stuff bits.
- send_EOP  out  1  high for the whole EOP (SE0) interval.
- tx_busy  out  1  high from the SYNC start until tx_done.
- tx_done  out  1  one-cycle pulse at the end of the packet.
- tx_err  out  1  one-cycle pulse on underrun.

## Operation
- Reset values: serial_out=1, enable_pts=0, send_EOP=0, tx_ready=1, tx_busy=0, tx_done=0, tx_err=0.
- After reset the FSM is in IDLE, the holding buffer is empty and the ones-count is 0.
- Holding buffer:
  - tx_ready = !buf_full (registered).
  - Accepting a byte sets buf_full. Moving the byte into the shift register clears it.
- FSM states: IDLE, SYNC, DATA, STUFF, EOP, JIDLE.
- IDLE: when buf_full, go to SYNC. The shift register is loaded with 8'h80. The bit timer restarts.
- SYNC: sends 0,0,0,0,0,0,0,1. At the end of its 8th bit period:
  - move the buffer byte into the shift register;
  - go to DATA.
- DATA: sends shift-register bits LSB-first. At the end of bit 7:
  - if buf_full: reload from the buffer and stay in DATA;
  - else if the current byte's last flag is set: go to EOP;
  - else (underrun): pulse tx_err and go to EOP.
- Bit stuffing:
  - The ones-count increments on every transmitted 1, including the final SYNC bit. It clears on every 0, including stuff bits.
  - When the count reaches 6 at the end of a bit period, the next bit period is STUFF. STUFF sends 0 and consumes no data bit.
  - STUFF then returns to the interrupted state or decision. This includes a stuff bit after the last data bit, before EOP.
- EOP: send_EOP=1 for 2 bit periods. serial_out=1 and enable_pts=0 throughout.
- JIDLE: send_EOP=0 for 1 bit period. Then pulse tx_done, clear tx_busy and go to IDLE.
- A new byte may be accepted during EOP/JIDLE. The next packet starts from IDLE after tx_done.
- Reset mid-packet: all outputs take their reset values immediately. The buffer content is discarded.

## Timing
- The bit timer counts 0..CLKS_PER_BIT-1. enable_pts=1 exactly when the count is 0 in SYNC/DATA/STUFF.
- serial_out changes only in cycles where enable_pts=1. It is held for CLKS_PER_BIT cycles.
- Latency: a byte is accepted at edge N in IDLE. buf_full is visible at N+1. The first SYNC bit with enable_pts appears at N+2.
- Packet length in cycles = CLKS_PER_BIT × (8 + 8·bytes + stuff_bits + 3).
- Buffer reload happens on the same edge that ends bit 7. There is no gap between bytes.
- The next tx_ready rises one cycle later.
- Simultaneous tx_valid acceptance and reload cannot occur, because tx_ready is low while the buffer is full.

## Configuration
- USB_TX_BITSTUFF_EN defined: stuffing operates as described above.
- USB_TX_BITSTUFF_EN undefined:
  - the STUFF state and ones-counter are removed;
  - bytes are sent raw (test mode for link bring-up);
  - all other behaviour is unchanged.

## Structure
- Package usb_tx_pkg holds:
  - the state enum (logic [2:0]);
  - SYNC_BYTE = 8'h80;
  - STUFF_LIMIT = 6;
  - EOP_BITS = 2.
- Sub-module usb_bit_timer: the CLKS_PER_BIT counter with restart input. It produces the bit-start strobe and the bit-end strobe.

## Test plan
- Reset check: assert n_rst low mid-idle → serial_out=1, enable_pts=0, send_EOP=0, tx_ready=1, tx_busy=0, tx_done=0, tx_err=0.
- Send 8'hA5 with tx_last=1 (CLKS_PER_BIT=4):
  - serial_out is sampled at each enable_pts and must read 0000000 1 10100101;
  - then send_EOP is high for 8 cycles, then 4 cycles of J;
  - tx_done pulses 76 cycles after the first SYNC strobe.
- Send 8'hFF then 8'h00 (last):
  - a stuffed 0 appears between FF bit4 and FF bit5;
  - 25 bit periods after SYNC;
  - no gap at the byte boundary.
- Send 8'hFC (last): bits 0,0,1,1,1,1,1,1 then a stuffed 0, then EOP. The stuff precedes send_EOP.
- Underrun: send 8'h12 with tx_last=0 and offer no further byte → tx_err pulses at the end of bit 7, then normal EOP/JIDLE and tx_done.
- Reset mid-DATA, plus a build without USB_TX_BITSTUFF_EN:
  - mid-DATA reset: outputs return to reset values on the reset edge;
  - without the macro, 8'hFF is sent as 8 raw ones with no stuff bit.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types and constants for the USB full-speed transmit
// serializer (usb_tx_shifter and usb_bit_timer).
//   tx_state_t  - serializer FSM state encoding
//   SYNC_BYTE   - SYNC pattern, sent LSB-first as 0000000 1
//   STUFF_LIMIT - run of ones after which a zero is stuffed
//   EOP_BITS    - SE0 length in bit periods
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DATA  = 3'd2,
        ST_STUFF = 3'd3,
        ST_EOP   = 3'd4,
        ST_JIDLE = 3'd5
    } tx_state_t;

    localparam logic [7:0]  SYNC_BYTE   = 8'h80;
    localparam int unsigned STUFF_LIMIT = 6;
    localparam int unsigned EOP_BITS    = 2;

endpackage

// File: rtl/usb_bit_timer.sv
// usb_bit_timer: bit-period counter for the USB transmit path.
//   clk, n_rst  - clock, asynchronous active-low reset
//   restart     - hold/force the count to 0 on the next edge
//   bit_start   - high while the count is 0 (first cycle of a bit period)
//   bit_end     - high while the count is CLKS_PER_BIT-1 (last cycle)
module usb_bit_timer
    import usb_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic restart,
    output logic bit_start,
    output logic bit_end
);

    localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_start = (cnt == '0);
    assign bit_end   = (cnt == LAST);

endmodule

// File: rtl/usb_tx_shifter.sv
// usb_tx_shifter: USB full-speed transmit byte serializer feeding the NRZI
// encoder. Prepends SYNC, shifts bytes LSB-first, stuffs a zero after six
// consecutive ones, then drives a 2-bit SE0 EOP and one J bit.
//   clk, n_rst     - clock, asynchronous active-low reset
//   tx_data        - packet byte
//   tx_valid       - tx_data/tx_last valid
//   tx_last        - byte is the last of the packet
//   tx_ready       - holding buffer empty (accept on tx_valid && tx_ready)
//   serial_out     - current line bit (0 = transition in the encoder)
//   enable_pts     - strobe in the first cycle of every transmitted bit
//   send_EOP       - high during the SE0 interval
//   tx_busy        - high from SYNC start until tx_done
//   tx_done        - one-cycle pulse at end of packet
//   tx_err         - one-cycle pulse on underrun
// Build option: define USB_TX_BITSTUFF_EN to enable bit stuffing; without it
// bytes are sent raw (link bring-up test mode).
module usb_tx_shifter
    import usb_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       enable_pts,
    output logic       send_EOP,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    tx_state_t  state;
    logic [7:0] buf_data;
    logic       buf_full;
    logic       buf_last;
    logic [6:0] sr;          // bits of the current byte not yet on the line
    logic       cur_last;
    logic [2:0] bit_idx;     // bit of the current byte on the line / EOP bit
    logic       shifting;    // in SYNC, DATA or STUFF
    logic       accept;
    logic       restart;
    logic       bit_start;
    logic       bit_end;

    // Where the stream goes after the current bit when no stuff is needed
    tx_state_t  pos_state;
    tx_state_t  adv_state;
    logic       adv_load;
    logic       adv_err;

`ifdef USB_TX_BITSTUFF_EN
    logic [2:0] ones;
    logic [2:0] ones_nxt;
    logic       do_stuff;
    tx_state_t  ret_state;
`endif

    assign accept  = tx_valid && tx_ready;
    assign restart = (state == ST_IDLE);

    usb_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .restart   (restart),
        .bit_start (bit_start),
        .bit_end   (bit_end)
    );

    // The timer is held at 0 in IDLE and every state change in the bit
    // states lands on a bit boundary, so the strobe is just bit_start gated
    // by the registered "shifting" flag.
    assign enable_pts = bit_start && shifting;

`ifdef USB_TX_BITSTUFF_EN
    always_comb begin
        ones_nxt = serial_out ? (ones + 3'd1) : '0;
        do_stuff = (state != ST_STUFF) && (ones_nxt == 3'(STUFF_LIMIT));
    end
`endif

    // A stuff bit defers the byte-boundary decision; resuming from STUFF
    // evaluates it exactly as if the stuffed bit had not been there.
    always_comb begin
`ifdef USB_TX_BITSTUFF_EN
        pos_state = (state == ST_STUFF) ? ret_state : state;
`else
        pos_state = state;
`endif
        adv_state = pos_state;
        adv_load  = 1'b0;
        adv_err   = 1'b0;
        if (bit_idx == 3'd7) begin
            if (pos_state == ST_SYNC || buf_full) begin
                adv_state = ST_DATA;
                adv_load  = 1'b1;
            end else begin
                adv_state = ST_EOP;
                adv_err   = !cur_last;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            buf_data   <= '0;
            buf_full   <= 1'b0;
            buf_last   <= 1'b0;
            sr         <= '0;
            cur_last   <= 1'b0;
            bit_idx    <= '0;
            shifting   <= 1'b0;
            tx_ready   <= 1'b1;
            serial_out <= 1'b1;
            send_EOP   <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
`ifdef USB_TX_BITSTUFF_EN
            ones       <= '0;
            ret_state  <= ST_DATA;
`endif
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;

            if (accept) begin
                buf_data <= tx_data;
                buf_last <= tx_last;
                buf_full <= 1'b1;
                tx_ready <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (buf_full) begin
                        state      <= ST_SYNC;
                        serial_out <= SYNC_BYTE[0];
                        sr         <= SYNC_BYTE[7:1];
                        bit_idx    <= '0;
                        shifting   <= 1'b1;
                        tx_busy    <= 1'b1;
`ifdef USB_TX_BITSTUFF_EN
                        ones       <= '0;
`endif
                    end
                end

                ST_SYNC, ST_DATA, ST_STUFF: begin
                    if (bit_end) begin
`ifdef USB_TX_BITSTUFF_EN
                        ones <= ones_nxt;
                        if (do_stuff) begin
                            ret_state  <= state;
                            state      <= ST_STUFF;
                            serial_out <= 1'b0;
                        end else
`endif
                        begin
                            state <= adv_state;
                            if (adv_load) begin
                                serial_out <= buf_data[0];
                                sr         <= buf_data[7:1];
                                cur_last   <= buf_last;
                                buf_full   <= 1'b0;
                                tx_ready   <= 1'b1;
                                bit_idx    <= '0;
                            end else if (adv_state == ST_EOP) begin
                                serial_out <= 1'b1;
                                send_EOP   <= 1'b1;
                                shifting   <= 1'b0;
                                bit_idx    <= '0;
                                tx_err     <= adv_err;
                            end else begin
                                serial_out <= sr[0];
                                sr         <= {1'b0, sr[6:1]};
                                bit_idx    <= bit_idx + 3'd1;
                            end
                        end
                    end
                end

                ST_EOP: begin
                    if (bit_end) begin
                        if (bit_idx == 3'(EOP_BITS - 1)) begin
                            state    <= ST_JIDLE;
                            send_EOP <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end

                ST_JIDLE: begin
                    if (bit_end) begin
                        state   <= ST_IDLE;
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
